// File: rtl/ysyx_24120013_imem_fetch_pkg.sv
// Shared definitions for the instruction-fetch bridge: state encoding and default widths.
package ysyx_24120013_pkg;
  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/ysyx_24120013_imem_fetch_if.sv
// Core-side fetch/inst channels and memory request/response channels of the fetch bridge.
interface ysyx_24120013_imem_fetch_if
  import ysyx_24120013_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF
);
  logic                  fetch_valid;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  fetch_ready;
  logic                  flush;
  logic [DATA_WIDTH-1:0] inst;
  logic                  inst_valid;
  logic                  inst_err;
  logic                  inst_ready;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_data;
  logic                  mem_rsp_err;

  modport slave (
    input  fetch_valid, fetch_pc, flush, inst_ready,
           mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    output fetch_ready, inst, inst_valid, inst_err, mem_req_valid, mem_req_addr
  );

  modport master (
    output fetch_valid, fetch_pc, flush, inst_ready,
           mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    input  fetch_ready, inst, inst_valid, inst_err, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/ysyx_24120013_imem_fetch_sat_updown_cnt.sv
// Saturating up/down counter; simultaneous inc and dec leave the count unchanged.
module ysyx_24120013_sat_updown_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (inc && !dec && cnt != '1)
      cnt <= cnt + W'(1);
    else if (dec && !inc && cnt != '0)
      cnt <= cnt - W'(1);
  end
endmodule

// File: rtl/ysyx_24120013_imem_fetch.sv
// Instruction-fetch bridge: one memory read per accepted PC, in-order responses,
// flush of in-flight fetches via a stale-response drop counter, and timeout reporting.
module ysyx_24120013_imem_fetch
  import ysyx_24120013_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_W_DEF,
  parameter int DATA_WIDTH  = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input logic                         clk,
  input logic                         rst,
  ysyx_24120013_imem_fetch_if.slave   bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  fetch_state_e          state;
  logic [TW-1:0]         tmo_cnt;
  logic                  pending_flush;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_vld;
  logic [DATA_WIDTH-1:0] inst_q;
  logic                  inst_vld;
  logic                  inst_err_q;
  logic [1:0]            drop_cnt;
  logic                  drop_inc;
  logic                  drop_dec;
  logic                  live_rsp;
  logic                  tmo_hit;

  assign bus.fetch_ready   = (state == IDLE) && (drop_cnt != 2'd3);
  assign bus.mem_req_valid = req_vld;
  assign bus.mem_req_addr  = req_addr;
  assign bus.inst          = inst_q;
  assign bus.inst_valid    = inst_vld;
  assign bus.inst_err      = inst_err_q;

  // Responses belonging to flushed/timed-out requests arrive first (in order) and are swallowed.
  assign live_rsp = bus.mem_rsp_valid && (drop_cnt == 2'd0);
  assign drop_dec = bus.mem_rsp_valid && (drop_cnt != 2'd0);
  assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    drop_inc = 1'b0;
    case (state)
      REQ:     drop_inc = bus.mem_req_ready && (pending_flush || bus.flush);
      WAIT:    drop_inc = !live_rsp && (bus.flush || tmo_hit);
      default: drop_inc = 1'b0;
    endcase
  end

  ysyx_24120013_sat_updown_cnt #(.W(2)) u_drop (
    .clk (clk),
    .rst (rst),
    .inc (drop_inc),
    .dec (drop_dec),
    .cnt (drop_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      req_vld       <= 1'b0;
      req_addr      <= '0;
      inst_q        <= '0;
      inst_vld      <= 1'b0;
      inst_err_q    <= 1'b0;
      tmo_cnt       <= '0;
      pending_flush <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.fetch_valid && bus.fetch_ready) begin
            req_addr <= bus.fetch_pc;
            req_vld  <= 1'b1;
            state    <= REQ;
          end
        end
        // The request cannot be withdrawn, so a flush here is remembered until acceptance.
        REQ: begin
          if (bus.mem_req_ready) begin
            req_vld       <= 1'b0;
            pending_flush <= 1'b0;
            tmo_cnt       <= '0;
            state         <= (pending_flush || bus.flush) ? IDLE : WAIT;
          end else if (bus.flush) begin
            pending_flush <= 1'b1;
          end
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (bus.flush) begin
            state <= IDLE;
          end else if (live_rsp) begin
            inst_q     <= bus.mem_rsp_err ? '0 : bus.mem_rsp_data;
            inst_err_q <= bus.mem_rsp_err;
            inst_vld   <= 1'b1;
            state      <= HOLD;
          end else if (tmo_hit) begin
            inst_q     <= '0;
            inst_err_q <= 1'b1;
            inst_vld   <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (bus.flush || bus.inst_ready) begin
            inst_vld   <= 1'b0;
            inst_err_q <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_24120013_imem_fetch.sv
// Scoreboard bench: driver pushes expected words, a memory model answers in order,
// a monitor compares whatever the bridge presents on the inst channel.
module tb_ysyx_24120013_imem_fetch;
  localparam int TMO   = 64;
  localparam int BOUND = 600;

  typedef struct {
    logic [31:0] addr;
    int          rdy_delay;
    int          lat;
    logic [31:0] data;
    logic        err;
  } cfg_t;
  typedef struct { logic [31:0] data; logic err; } exp_t;
  typedef struct { int due; logic [31:0] data; logic err; } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  cfg_t cfg_q[$];
  exp_t exp_q[$];
  rsp_t rsp_q[$];

  ysyx_24120013_imem_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ysyx_24120013_imem_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYC(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(string nm);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endfunction

  // Memory model: fixed accept delay and response latency per request, strictly in order.
  initial begin
    int   t, cnt, last_due, due;
    cfg_t c;
    rsp_t r;
    t = 0; cnt = 0; last_due = 0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.mem_rsp_err   = 1'b0;
    forever begin
      @(posedge clk); #1;
      t++;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = $urandom;
      bus.mem_rsp_err   = 1'b0;
      if (rsp_q.size() > 0 && rsp_q[0].due <= t) begin
        r = rsp_q.pop_front();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = r.data;
        bus.mem_rsp_err   = r.err;
      end
      bus.mem_req_ready = bus.mem_req_valid && cfg_q.size() > 0 && cnt >= cfg_q[0].rdy_delay;
      @(negedge clk);
      if (rst) begin
        rsp_q.delete();
        cfg_q.delete();
        cnt = 0;
        last_due = 0;
      end else if (bus.mem_req_valid) begin
        if (cfg_q.size() == 0) fail_now("unexpected_req");
        else begin
          chk("req_addr", bus.mem_req_addr, cfg_q[0].addr);
          if (bus.mem_req_ready) begin
            c   = cfg_q.pop_front();
            due = (t + c.lat > last_due + 1) ? t + c.lat : last_due + 1;
            last_due = due;
            rsp_q.push_back('{due, c.data, c.err});
            cnt = 0;
          end else cnt++;
        end
      end
    end
  end

  // Monitor: every cycle the word is presented it must equal the head expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.inst_valid) begin
        if (exp_q.size() == 0) fail_now("unexpected_inst_valid");
        else begin
          chk("inst", bus.inst, exp_q[0].data);
          chk("inst_err", {31'd0, bus.inst_err}, {31'd0, exp_q[0].err});
          if (bus.inst_ready || bus.flush) void'(exp_q.pop_front());
        end
      end
    end
  end

  // fmode: 0 none, 1 flush while request pending, 2 flush while waiting, 3 flush while holding.
  task automatic do_fetch(input logic [31:0] addr, input int rdy, input int lat,
                          input logic [31:0] data, input logic err, input int fmode,
                          input int k, input int hold, input int exp_lat, input bit rst_hold);
    exp_t e;
    int   w, n, v;
    cfg_q.push_back('{addr, rdy, lat, data, err});
    e.err  = err || (lat > TMO);
    e.data = e.err ? 32'd0 : data;
    if (fmode == 0 || fmode == 3) exp_q.push_back(e);
    @(posedge clk); #1;
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = addr;
    w = 0;
    forever begin
      @(negedge clk);
      if (bus.fetch_ready) break;
      w++;
      if (w > BOUND) begin
        fail_now("fetch_accept_timeout");
        bus.fetch_valid = 1'b0;
        return;
      end
    end
    n = cyc;
    @(posedge clk); #1;
    bus.fetch_valid = 1'b0;
    if (fmode == 1) begin
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      return;
    end
    if (fmode == 2) begin
      w = 0;
      forever begin
        @(negedge clk);
        if (bus.mem_req_valid && bus.mem_req_ready) break;
        w++;
        if (w > BOUND) begin
          fail_now("mem_accept_timeout");
          return;
        end
      end
      repeat (k - 1) @(posedge clk);
      @(posedge clk); #1;
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      return;
    end
    w = 0;
    forever begin
      @(negedge clk);
      if (bus.inst_valid) break;
      w++;
      if (w > BOUND) begin
        fail_now("inst_valid_timeout");
        return;
      end
    end
    v = cyc;
    if (exp_lat >= 0) chk("latency", v - n, exp_lat);
    if (rst_hold) begin
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      return;
    end
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    if (fmode == 3) begin
      bus.flush      = 1'b1;
      bus.inst_ready = 1'($urandom_range(0, 1));
    end else bus.inst_ready = 1'b1;
    @(posedge clk); #1;
    bus.inst_ready = 1'b0;
    bus.flush      = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int fmode, rdy, lat, k, hold, w;
    bus.fetch_valid = 1'b0;
    bus.fetch_pc    = '0;
    bus.flush       = 1'b0;
    bus.inst_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_fetch_ready", {31'd0, bus.fetch_ready}, 32'd1);
    chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_inst_err", {31'd0, bus.inst_err}, 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_mem_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    chk("rst_mem_req_addr", bus.mem_req_addr, 32'd0);
    chk("rst_drop_cnt", {30'd0, dut.drop_cnt}, 32'd0);

    do_fetch(32'h8000_0000, 0, 1, 32'h0010_0093, 1'b0, 0, 0, 0, 3, 1'b0);
    do_fetch(32'h8000_0010, 5, 1, 32'h0020_0113, 1'b0, 0, 0, 1, 8, 1'b0);
    do_fetch(32'h8000_0020, 0, 4, 32'hDEAD_BEEF, 1'b0, 2, 1, 0, -1, 1'b0);
    do_fetch(32'h8000_0004, 0, 1, 32'h0000_0013, 1'b0, 0, 0, 0, -1, 1'b0);
    do_fetch(32'h8000_0030, 0, TMO + 6, 32'hCAFE_F00D, 1'b0, 0, 0, 0, -1, 1'b0);
    chk("timeout_drop_cnt", {30'd0, dut.drop_cnt}, 32'd1);
    do_fetch(32'h8000_0034, 0, 1, 32'h0000_0093, 1'b0, 0, 0, 0, -1, 1'b0);
    do_fetch(32'h8000_0040, 0, 2, 32'h1234_5678, 1'b1, 0, 0, 2, -1, 1'b0);
    do_fetch(32'h8000_0044, 2, 3, 32'h0000_1111, 1'b0, 1, 0, 0, -1, 1'b0);
    do_fetch(32'h8000_0048, 0, 1, 32'h0000_2222, 1'b0, 3, 0, 1, -1, 1'b0);

    do_fetch(32'h8000_0050, 0, TMO + 20, 32'h1111_1111, 1'b0, 0, 0, 0, -1, 1'b1);
    @(negedge clk);
    chk("rst_hold_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_hold_fetch_ready", {31'd0, bus.fetch_ready}, 32'd1);
    chk("rst_hold_drop_cnt", {30'd0, dut.drop_cnt}, 32'd0);
    do_fetch(32'h8000_0054, 0, 1, 32'h0000_3333, 1'b0, 0, 0, 0, 3, 1'b0);

    for (int i = 0; i < 3; i++)
      do_fetch(32'h8000_0060 + 32'(i * 4), 0, 40, 32'hBAD0_0000 + 32'(i), 1'b0, 2, 1, 0, -1, 1'b0);
    @(negedge clk);
    chk("sat_fetch_ready", {31'd0, bus.fetch_ready}, 32'd0);
    chk("sat_drop_cnt", {30'd0, dut.drop_cnt}, 32'd3);
    do_fetch(32'h8000_0070, 0, 1, 32'h0000_4444, 1'b0, 0, 0, 0, -1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      fmode = $urandom_range(0, 3);
      rdy   = $urandom_range(0, 3);
      lat   = $urandom_range(1, 6);
      if ((fmode == 0 || fmode == 3) && $urandom_range(0, 7) == 0) lat = TMO + $urandom_range(4, 10);
      if (fmode == 1 && rdy == 0) rdy = 1;
      if (fmode == 2 && lat < 2) lat = 2;
      k    = $urandom_range(1, lat - 1 > 4 ? 4 : (lat > 1 ? lat - 1 : 1));
      hold = $urandom_range(0, 3);
      do_fetch(32'h8000_0000 + 32'($urandom_range(0, 1023) * 4), rdy, lat, $urandom,
               1'($urandom_range(0, 7) == 0), fmode, k, hold, -1, 1'b0);
    end

    w = 0;
    while ((cfg_q.size() != 0 || rsp_q.size() != 0) && w < BOUND) begin
      @(posedge clk);
      w++;
    end
    if (w >= BOUND) fail_now("drain_timeout");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("end_drop_cnt", {30'd0, dut.drop_cnt}, 32'd0);
    chk("end_fetch_ready", {31'd0, bus.fetch_ready}, 32'd1);
    chk("end_exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
